// File: rtl/adc_sample_conditioner_pkg.sv
// Shared definitions for the ADC conditioning path: fmt encodings, internal
// width derivation and the field extension helper.
package adc_sample_conditioner_pkg;

    localparam logic FMT_UNSIGNED = 1'b0;
    localparam logic FMT_SIGNED   = 1'b1;

    // Two guard bits so ext(field) - OFFSET can never wrap.
    function automatic int calc_iw(input int sel_w, input int out_w);
        return ((sel_w > out_w) ? sel_w : out_w) + 2;
    endfunction

    // Fill bit used above the field MSB when widening it.
    function automatic logic ext_fill(input logic msb, input logic fmt);
        return (fmt == FMT_SIGNED) ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/adc_sample_conditioner_sat_clip.sv
// Combinational signed clip of IN_W bits into OUT_W bits with a clip flag.
module sat_clip #(
    parameter int IN_W  = 20,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    logic [IN_W-OUT_W:0] hi;

    // In range exactly when every bit from the output sign bit up agrees.
    assign hi   = din[IN_W-1:OUT_W-1];
    assign clip = !((&hi) || !(|hi));

    always_comb begin
        dout = din[OUT_W-1:0];
        if (clip)
            dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
    end

endmodule

// File: rtl/adc_sample_conditioner.sv
// ADC front-end: field extract/extend, offset removal, optional block
// averaging and saturation into a signed control word.
module adc_sample_conditioner
    import adc_sample_conditioner_pkg::*;
#(
    parameter int IN_W            = 12,
    parameter int SEL_LSB         = 0,
    parameter int SEL_W           = 8,
    parameter int OUT_W           = 16,
    parameter int signed OFFSET   = 1,
    parameter int AVG_LOG2        = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [IN_W-1:0]         in_data,
    input  logic                    fmt,
    input  logic                    avg_en,
    input  logic                    clear,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat
);

    localparam int IW = calc_iw(SEL_W, OUT_W);
    localparam int AW = IW + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CMAX = CW'((1 << AVG_LOG2) - 1);

    logic [SEL_W-1:0]     fld;
    logic [IW-1:0]        xe;
    logic                 a_valid;
    logic signed [IW-1:0] a_x;
    logic signed [AW-1:0] acc, sum, pre;
    logic [CW-1:0]        cnt;
    logic                 avg_q, tog_q, clr;
    logic signed [OUT_W-1:0] clip_d;
    logic                 clip_f;
    logic                 unused_in;

    assign unused_in = ^in_data;
    assign fld = in_data[SEL_LSB +: SEL_W];
    assign xe  = {{(IW-SEL_W){ext_fill(fld[SEL_W-1], fmt)}}, fld};

    // A mode change seen at one edge flushes the block on the following edge.
    assign clr = clear | tog_q;
    assign sum = acc + AW'(a_x);
    assign pre = avg_en ? (sum >>> AVG_LOG2) : AW'(a_x);

    sat_clip #(.IN_W(AW), .OUT_W(OUT_W)) u_clip (
        .din  (pre),
        .dout (clip_d),
        .clip (clip_f)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid   <= 1'b0;
            a_x       <= '0;
            acc       <= '0;
            cnt       <= '0;
            avg_q     <= 1'b0;
            tog_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            // Stage A always captures, even under clear: that sample opens the next block.
            a_valid   <= in_valid;
            if (in_valid)
                a_x <= $signed(xe) - IW'(OFFSET);
            avg_q     <= avg_en;
            tog_q     <= avg_en ^ avg_q;
            out_valid <= 1'b0;
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (a_valid) begin
                if (!avg_en || cnt == CMAX) begin
                    out_data  <= clip_d;
                    out_sat   <= clip_f;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: doc/adc_sample_conditioner.md
# adc_sample_conditioner

Parametrised front-end conditioner between the ADC sample interface and the servo control loop. It extracts a configurable bit field from each raw ADC word and interprets it as signed or unsigned. It subtracts a fixed offset and optionally averages blocks of 2^AVG_LOG2 samples. It then saturates the result into a signed control-word width, so the error/PID path receives one clean, flagged, valid-qualified word per block.

## Interface
- IN_W, 12: raw ADC word width.
- SEL_LSB, 0: LSB index of the extracted field.
- SEL_W, 8: extracted field width. Requires SEL_LSB+SEL_W ≤ IN_W.
- OUT_W, 16: signed output width.
- OFFSET, 1: signed constant subtracted from every extracted sample.
- AVG_LOG2, 2: log2 of the averaging block length. Range 0..6.
- clk, input, 1: single clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_data carries a new sample this cycle. There is no backpressure, and in_valid may be high every cycle.
- in_data, input, IN_W: raw ADC word.
- fmt, input, 1: 0 means the field is unsigned and is zero-extended. 1 means the field is two's complement and is sign-extended.
- avg_en, input, 1: 1 averages blocks of 2^AVG_LOG2 samples. 0 passes each sample through individually.
- clear, input, 1: synchronous flush of any partial block.
- out_valid, output, 1: one-cycle strobe marking a new result.
- out_data, output, OUT_W: signed result. Held between strobes.
- out_sat, output, 1: the result was clipped. Updated only with out_valid.

## Operation
- **Stage A** (registered on in_valid):
  - x = ext(in_data[SEL_LSB +: SEL_W], fmt) − OFFSET.
  - Computed at internal width IW = max(SEL_W, OUT_W) + 2. This width never overflows.
  - Sets a_valid.
- **Stage B, avg_en = 0:** on a_valid, out_data = sat(x), out_sat = clip flag, and out_valid is strobed.
- **Stage B, avg_en = 1:**
  - Accumulator acc is IW + AVG_LOG2 bits wide. Counter cnt runs 0..2^AVG_LOG2−1.
  - On a_valid with cnt < max: acc += x and cnt++.
  - On a_valid with cnt = max: out_data = sat((acc + x) >>> AVG_LOG2). The shift is arithmetic, i.e. floor toward −∞.
  - In that same cycle out_sat is set, out_valid is strobed, acc is set to 0 and cnt wraps to 0.
- **Saturation:** clip to [−2^(OUT_W−1), 2^(OUT_W−1)−1] and set out_sat = 1 when clipped, else 0.
- **fmt:** sampled into stage A together with in_data. Changing it mid-block only affects later samples.
- **avg_en change:** any toggle is treated as clear, one cycle after it is seen.
- **clear at cycle t:**
  - The stage-A content held at t is discarded, and acc and cnt are zeroed.
  - An in_valid sample presented at t is captured into stage A and becomes the first sample of the next block.
  - out_data and out_sat hold, and no strobe is issued.
- **reset:** out_valid = 0, out_data = 0, out_sat = 0, a_valid = 0, acc = 0, cnt = 0, and the stored previous avg_en = 0. reset overrides clear and in_valid in the same cycle.

## Timing
- **Latency:** out_valid rises 2 cycles after the in_valid that completes a result. In pass-through that is every sample; in averaging it is the 2^AVG_LOG2-th sample.
- **Throughput:**
  - One sample per cycle sustained.
  - Pass-through with in_valid held high gives back-to-back out_valid.
  - Averaging with in_valid held high gives one strobe per 2^AVG_LOG2 cycles.
- **Strobe width:** out_valid is high for exactly one cycle per result and never two cycles for one block.
- **AVG_LOG2 = 0:** avg_en has no observable effect. Behaviour is identical to pass-through.

## Structure
- **Shared package/include:**
  - FMT_UNSIGNED = 0 and FMT_SIGNED = 1 encodings.
  - The IW derivation.
  - A sign/zero-extension function.
- **Sub-module `sat_clip`:**
  - Parameters IN_W and OUT_W.
  - Combinational signed clip with a clip flag.
  - Reused later by the PID output stage.
- **Top level:** stage-A register, accumulator/counter, output register.

## Test plan
All cases use default parameters unless stated.
- **Reset:** hold reset 3 cycles with in_valid = 1 → out_valid = 0, out_data = 0, out_sat = 0 throughout, and for 2 cycles after release.
- **Pass-through:** avg_en = 0.
  - fmt = 1, in_data = 12'hA05 → out_data = 4 two cycles later.
  - fmt = 1, in_data = 12'h080 → out_data = −129 (16'hFF7F).
  - fmt = 0, in_data = 12'h0FF → 254.
  - All with out_sat = 0.
- **Averaging:** avg_en = 1, fmt = 1, back-to-back.
  - Fields 10, 11, 12, 13 → single strobe with out_data = 10, two cycles after the 4th sample.
  - Fields −1, −1, −1, 0 → out_data = −2 (floor of −7/4).
- **Saturation:** build with OUT_W = 8.
  - fmt = 0, field 255 → out_data = 127, out_sat = 1.
  - fmt = 1, field 0x80 → out_data = −128, out_sat = 1.
  - Next sample with field 5 → out_data = 4, out_sat = 0.
- **Clear mid-block:** avg_en = 1.
  - Samples 1 and 2 are fields 100, 100.
  - Clear is asserted together with sample 3 (field 8); samples 4–6 are fields 8, 8, 8.
  - Required: exactly one strobe, out_data = 7.
- **Mode toggle and reset mid-block:**
  - Toggle avg_en after 2 samples → that partial block is never emitted.
  - Assert reset after 3 samples of a new block → no strobe, and the next 4 samples produce a correct fresh average.
